// File: rtl/ifu_fetch_buf.sv
// Instruction fetch unit: credit-bounded in-order fetch into a DEPTH-entry {pc, inst} buffer, with redirect/flush.
// Latency: grant in cycle N, response in N+1, head visible to decode in N+2; 1 inst/cycle sustained.
// Backpressure: out_ready=0 fills the buffer; new requests stop once buffer + in-flight + stale reach DEPTH.
module ifu_fetch_buf #(
    parameter int               XLEN     = 64,
    parameter int               ILEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             inst_ena,
    output logic [XLEN-1:0]  inst_addr,
    input  logic             inst_gnt,
    input  logic             inst_rvalid,
    input  logic [ILEN-1:0]  inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  out_inst,
    output logic [XLEN-1:0]  out_pc,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = AW + 3;

    logic [XLEN-1:0] pc;
    logic            run;

    // Instruction buffer: registered storage, head read straight from the array.
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [ILEN-1:0] fifo_inst [DEPTH];
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;

    // Addresses of requests granted but not yet answered (live requests only).
    logic [XLEN-1:0] ipq [DEPTH];
    logic [CW-1:0]   ipq_wr;
    logic [CW-1:0]   ipq_rd;

    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop;

    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   credit_used;
    logic            issue;
    logic            resp_any;
    logic            resp_drop;
    logic            resp_keep;
    logic            pop;
    logic [XLEN-1:0] redirect_pc_aligned;

    assign fifo_count  = wr_ptr - rd_ptr;
    assign credit_used = SW'(fifo_count) + SW'(outst) + SW'(drop);

    assign inst_ena  = run && (credit_used < SW'(DEPTH));
    assign inst_addr = pc;
    assign issue     = inst_ena && inst_gnt;

    // A response with nothing outstanding and nothing to drop is a protocol error and is ignored.
    assign resp_any  = inst_rvalid && ((drop != '0) || (outst != '0));
    assign resp_drop = inst_rvalid && (drop != '0);
    assign resp_keep = inst_rvalid && (drop == '0) && (outst != '0);

    assign out_valid = (fifo_count != '0);
    assign out_inst  = fifo_inst[rd_ptr[AW-1:0]];
    assign out_pc    = fifo_pc[rd_ptr[AW-1:0]];
    assign pop       = out_valid && out_ready;

    assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);

    // Fetch PC and run flag; run rises on the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= RESET_PC;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                pc <= redirect_pc_aligned;
            end else if (issue) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    // Pointers and credit counters; redirect converts everything in flight (and this cycle's grant) to stale,
    // minus the response that returns on the redirect edge itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ipq_wr <= '0;
            ipq_rd <= '0;
            outst  <= '0;
            drop   <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ipq_wr <= '0;
            ipq_rd <= '0;
            outst  <= '0;
            drop   <= drop + outst + CW'(issue) - CW'(resp_any);
        end else begin
            if (resp_keep) begin
                wr_ptr <= wr_ptr + CW'(1);
                ipq_rd <= ipq_rd + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (issue) begin
                ipq_wr <= ipq_wr + CW'(1);
            end
            if (resp_drop) begin
                drop <= drop - CW'(1);
            end
            outst <= outst + CW'(issue) - CW'(resp_keep);
        end
    end

    // Buffer storage: a live response is paired with the oldest in-flight address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (resp_keep && !redirect) begin
            fifo_pc[wr_ptr[AW-1:0]]   <= ipq[ipq_rd[AW-1:0]];
            fifo_inst[wr_ptr[AW-1:0]] <= inst;
        end
    end

    // In-flight address queue storage; contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (issue && !redirect) begin
            ipq[ipq_wr[AW-1:0]] <= pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
module tb_ifu_fetch_buf;

    localparam int          XLEN     = 64;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             inst_ena;
    logic [XLEN-1:0]  inst_addr;
    logic             inst_gnt = 1'b0;
    logic             inst_rvalid = 1'b0;
    logic [ILEN-1:0]  inst = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ILEN-1:0]  out_inst;
    logic [XLEN-1:0]  out_pc;
    logic             redirect = 1'b0;
    logic [XLEN-1:0]  redirect_pc = '0;

    ifu_fetch_buf #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_ena(inst_ena), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Reference model: memory request list (oldest first) and expected decode stream.
    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } req_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        mem_q[$];
    ent_t        exp_q[$];
    logic [63:0] popped[$];
    logic [63:0] m_pc = RESET_PC;
    bit          m_run = 1'b0;
    int          cyc = 0;
    int          last_due = 0;
    int          grants = 0;

    int p_gnt = 100, p_ready = 100, p_redir = 0, lat_min = 1, lat_max = 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] popped_at(input int idx);
        if (idx < popped.size()) return popped[idx];
        return '1;
    endfunction

    // One clock: called at a negedge, drives inputs, lets the edge happen, updates model, checks outputs.
    task automatic step(input bit frc, input logic [63:0] rtgt);
        bit          exp_ena, exp_vld, g, rv, rdy, rd;
        logic [63:0] rpc;
        req_t        r;
        ent_t        e;
        int          lat, due;
        exp_ena = m_run && ((exp_q.size() + mem_q.size()) < DEPTH);
        exp_vld = (exp_q.size() != 0);
        g   = ($urandom_range(99) < p_gnt);
        rdy = ($urandom_range(99) < p_ready);
        rv  = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        rd  = frc || ($urandom_range(999) < p_redir);
        rpc = frc ? rtgt : {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_ffff)};
        inst_gnt    = g;
        inst_rvalid = rv;
        inst        = rv ? mem_q[0].data : $urandom;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        if (exp_vld && rdy) begin
            e = exp_q.pop_front();
            popped.push_back(e.pc);
        end
        if (rv) begin
            r = mem_q.pop_front();
            if (!r.stale) begin
                e.pc = r.addr;
                e.data = r.data;
                exp_q.push_back(e);
            end
        end
        if (exp_ena && g) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = m_pc;
            r.data = $urandom;
            r.due = due;
            r.stale = 1'b0;
            mem_q.push_back(r);
            m_pc = m_pc + 64'd4;
            grants++;
        end
        if (rd) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_q.delete();
            m_pc = rpc & ~64'h3;
        end
        m_run = 1'b1;
        cyc++;
        @(negedge clk);
        inst_gnt = 1'b0;
        inst_rvalid = 1'b0;
        redirect = 1'b0;
        exp_ena = m_run && ((exp_q.size() + mem_q.size()) < DEPTH);
        check("inst_ena", inst_ena, exp_ena);
        check("inst_addr", inst_addr, m_pc);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_pc", out_pc, exp_q[0].pc);
            check("out_inst", out_inst, exp_q[0].data);
        end
    endtask

    // Asynchronous reset: outputs must clear immediately, then after 3 held cycles release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        inst_gnt = 1'b0; inst_rvalid = 1'b0; redirect = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_async_ena", inst_ena, 1'b0);
        check("rst_async_vld", out_valid, 1'b0);
        check("rst_async_addr", inst_addr, RESET_PC);
        mem_q.delete();
        exp_q.delete();
        m_pc = RESET_PC;
        m_run = 1'b0;
        last_due = 0;
        repeat (3) @(negedge clk);
        check("rst_ena", inst_ena, 1'b0);
        check("rst_vld", out_valid, 1'b0);
        check("rst_addr", inst_addr, RESET_PC);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_inst", out_inst, 64'h0);
        rst = 1'b1;
        #1;
        check("rel_ena_not_yet", inst_ena, 1'b0);
    endtask

    initial begin
        int base, g0;

        // Streaming with single-cycle memory.
        do_reset();
        p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1; p_redir = 0;
        step(1'b0, '0);
        check("first_ena", inst_ena, 1'b1);
        repeat (2) step(1'b0, '0);
        check("stream_first_pc", out_pc, RESET_PC);
        base = popped.size();
        repeat (16) step(1'b0, '0);
        check("stream_rate", popped.size() - base, 16);
        check("stream_pc2", popped_at(2), RESET_PC + 64'd8);

        // Backpressure: exactly DEPTH grants, then drain and resume in order.
        do_reset();
        p_ready = 0;
        base = popped.size();
        g0 = grants;
        repeat (12) step(1'b0, '0);
        check("bp_grants", grants - g0, DEPTH);
        p_ready = 100;
        repeat (10) step(1'b0, '0);
        check("bp_pop0", popped_at(base), RESET_PC);
        check("bp_pop4", popped_at(base + 4), RESET_PC + 64'h10);
        check("bp_pop5", popped_at(base + 5), RESET_PC + 64'h14);

        // Redirect with two requests outstanding on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        p_gnt = 0;
        step(1'b0, '0);
        p_gnt = 100;
        repeat (2) step(1'b0, '0);
        p_gnt = 0;
        step(1'b1, 64'h8000_1000);
        base = popped.size();
        p_gnt = 100;
        repeat (14) step(1'b0, '0);
        check("redir2_first", popped_at(base), 64'h8000_1000);
        check("redir2_second", popped_at(base + 1), 64'h8000_1004);

        // Redirect on a cycle that also has a grant and a response.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (8) step(1'b0, '0);
        step(1'b1, 64'h8000_2000);
        base = popped.size();
        repeat (8) step(1'b0, '0);
        check("redir_coinc_first", popped_at(base), 64'h8000_2000);

        // Misaligned redirect target.
        p_gnt = 0;
        step(1'b1, 64'h8000_1006);
        check("misaligned_addr", inst_addr, 64'h8000_1004);

        // Randomized traffic with redirects and variable latency.
        p_redir = 30; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            p_gnt   = (i % 500 < 250) ? 100 : 60;
            p_ready = (i % 300 < 100) ? 100 : 50;
            step(1'b0, '0);
        end

        // Reset in the middle of traffic, then restart.
        do_reset();
        p_redir = 0; p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 2;
        base = popped.size();
        repeat (20) step(1'b0, '0);
        check("post_reset_first", popped_at(base), RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_buf.md
# ifu_fetch_buf

Parametrised instruction-fetch unit with in-order request/response memory handshake, a DEPTH-entry instruction buffer and PC redirect/flush. It sits between instruction memory and the decode stage, replacing the free-running single-cycle PC generator. Fetched words are handed to decode over a valid/ready interface together with their PC. A credit scheme bounds the number of in-flight requests so the buffer can never overflow.

## Interface
- XLEN, 64, address/PC width
- ILEN, 32, instruction width
- DEPTH, 4, buffer entries and maximum in-flight requests; power of two, ≥2
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_ena  out  1  fetch request valid
- inst_addr  out  XLEN  fetch address; always word aligned
- inst_gnt  in  1  memory accepts the request this cycle; meaningful only when inst_ena=1
- inst_rvalid  in  1  response valid; responses return in request order, earliest the cycle after the grant
- inst  in  ILEN  response data
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts the head
- out_inst  out  ILEN  head instruction
- out_pc  out  XLEN  head PC
- redirect  in  1  flush and restart fetch, single-cycle pulse
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0

## Operation
- State: pc register, run flag, circular FIFO with DEPTH entries of {pc, inst}, wr/rd pointers with an extra wrap bit, an outstanding counter `outst`, a stale-drop counter `drop`, and a PC queue of in-flight request addresses. Counters are clog2(DEPTH)+1 bits.
- Credit rule: inst_ena = run && (fifo_count + outst + drop < DEPTH). Stale requests hold their credit until their response returns.
- Issue: inst_ena && inst_gnt pushes pc into the in-flight PC queue and increments outst. pc advances by 4 on the next edge, wrapping modulo 2^XLEN.
- Response:
  - inst_rvalid with drop>0: decrement drop and discard the data.
  - inst_rvalid with drop=0: push {popped in-flight PC, inst} into the FIFO and decrement outst.
- Pop: out_valid && out_ready advances rd pointer. out_valid = FIFO not empty. out_inst and out_pc come from a registered head, with no bypass from the response.
- Redirect, which has priority over all other updates on that edge:
  - FIFO is cleared.
  - drop <= drop + outst + (inst_ena && inst_gnt); outst <= 0.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - An inst_rvalid in the same cycle is treated as stale: it is discarded and not counted against the new drop value.
  - A pop in the same cycle is considered consumed by decode and needs no special action.
- A response arriving with outst=0 and drop=0 is a protocol error. It is ignored and no counter underflows.

## Timing
- Reset values (asynchronous, while rst=0):
  - pc = RESET_PC, run = 0, inst_ena = 0, inst_addr = RESET_PC
  - out_valid = 0, out_inst = 0, out_pc = 0
  - all pointers and counters = 0
- run is set on the first rising edge with rst=1, so the first request is presented one cycle after reset release.
- Latency:
  - Grant in cycle N with rvalid in cycle N+1 gives out_valid in cycle N+2.
  - Sustained throughput is 1 instruction per cycle with out_ready=1 and single-cycle memory.
- After redirect in cycle N, inst_addr = redirect_pc from cycle N+1. inst_ena in N+1 still obeys the credit rule.
- Full: with fifo_count = DEPTH, inst_ena = 0. Simultaneous pop and push when full cannot occur, because the credit rule prevents it.
- Reset asserted mid-operation clears all state immediately; in-flight responses after reset release are not tolerated, since the memory is reset together with the unit.

## Test plan
- Reset: hold rst=0 for 3 cycles -> inst_ena=0, out_valid=0, inst_addr=0x80000000. Release -> inst_ena=1 one cycle later.
- Streaming: inst_gnt=1, 1-cycle rvalid, out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008…, one per cycle, with inst data matching.
- Backpressure: out_ready=0, DEPTH=4 -> exactly 4 grants, then inst_ena=0. Raise out_ready -> 4 pops, then streaming resumes at 0x80000010 with no gaps or duplicates.
- Redirect with 2 outstanding (3-cycle memory latency): redirect_pc=0x80001000 -> 2 stale responses dropped, next out_pc=0x80001000.
- Redirect coinciding with both a grant and an rvalid -> that rvalid is discarded, the granted request is counted as stale, and the first delivered out_pc is the redirect target.
- Misaligned redirect_pc=0x80001006 -> inst_addr=0x80001004.
